// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer
// Desc     : 4-entry circular store buffer with load-conflict detection.
//            Define WRITE_MERGE_EN to merge same-word stores into the tail.
// Revision : 1.0  initial release
// ============================================================================
module store_write_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic        wr_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] rd_addr,
    output logic        rd_conflict,
    output logic [2:0]  count,
    output logic        empty
);

    localparam int c_DEPTH = 4;

    logic [29:0] r_addr [c_DEPTH];
    logic [31:0] r_data [c_DEPTH];
    logic [3:0]  r_be   [c_DEPTH];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_DEPTH-1:0] w_match;
    logic               w_unused_bits;

    assign count     = r_count;
    assign empty     = (r_count == 3'd0);
    assign wr_ready  = (r_count < 3'd4);
    assign mem_req   = !empty;
    assign mem_addr  = {r_addr[r_head], 2'b00};
    assign mem_wdata = r_data[r_head];
    assign mem_be    = r_be[r_head];

    // A store with no byte lanes enabled carries no data and is dropped.
    assign w_accept = wr_valid && wr_ready && (wr_be != 4'b0000);
    assign w_pop    = mem_req && mem_ack;

    assign w_unused_bits = &{1'b0, wr_addr[1:0], rd_addr[1:0]};

`ifdef WRITE_MERGE_EN
    logic [1:0] w_last;
    logic       w_merge;

    // Requiring two entries keeps the head, which may already be on the bus, untouched.
    assign w_last  = r_tail - 2'd1;
    assign w_merge = w_accept && (r_count >= 3'd2) && (r_addr[w_last] == wr_addr[31:2]);
    assign w_push  = w_accept && !w_merge;
`else
    assign w_push  = w_accept;
`endif

    generate
        for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_match
            logic [1:0] w_offset;
            assign w_offset    = 2'(gi) - r_head;
            assign w_match[gi] = ({1'b0, w_offset} < r_count) && (r_addr[gi] == rd_addr[31:2]);
        end
    endgenerate

    assign rd_conflict = |w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_be[i] <= 4'b0000;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= wr_addr[31:2];
                r_data[r_tail] <= wr_data;
                r_be[r_tail]   <= wr_be;
                r_tail         <= r_tail + 2'd1;
            end
`ifdef WRITE_MERGE_EN
            if (w_merge) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) begin
                        r_data[w_last][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
                r_be[w_last] <= r_be[w_last] | wr_be;
            end
`endif
            if (w_pop) begin
                r_head <= r_head + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_write_buffer
// Desc     : Scoreboard bench for store_write_buffer: queue-based reference
//            model, per-cycle monitor, directed scenarios plus random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] rd_addr;
    logic        rd_conflict;
    logic [2:0]  count;
    logic        empty;

    store_write_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ready   (wr_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .rd_addr    (rd_addr),
        .rd_conflict(rd_conflict),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered list of pending stores.
    int   m_n;
    bit   m_acc;
    bit   m_pop;
    bit   m_mrg;
    ent_t m_e;
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            m_n   = exp_q.size();
            m_acc = wr_valid && (m_n < 4) && (wr_be != 4'b0000);
            m_pop = (m_n > 0) && mem_ack;
            m_mrg = 1'b0;
            if (m_acc) begin
`ifdef WRITE_MERGE_EN
                if (m_n >= 2 && exp_q[m_n-1].waddr == wr_addr[31:2]) begin
                    m_mrg = 1'b1;
                    m_e   = exp_q[m_n-1];
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[b]) m_e.data[8*b +: 8] = wr_data[8*b +: 8];
                    end
                    m_e.be = m_e.be | wr_be;
                    exp_q[m_n-1] = m_e;
                end
`endif
                if (!m_mrg) begin
                    m_e.waddr = wr_addr[31:2];
                    m_e.data  = wr_data;
                    m_e.be    = wr_be;
                    exp_q.push_back(m_e);
                end
            end
            if (m_pop) void'(exp_q.pop_front());
        end
    end

    // Monitor: compares every visible output against the model mid-cycle.
    int mon_n;
    bit mon_conf;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_n    = exp_q.size();
            mon_conf = 1'b0;
            for (int i = 0; i < mon_n; i++) begin
                if (exp_q[i].waddr == rd_addr[31:2]) mon_conf = 1'b1;
            end
            check("mon_count", {29'd0, count}, mon_n);
            check("mon_empty", {31'd0, empty}, {31'd0, mon_n == 0});
            check("mon_wr_ready", {31'd0, wr_ready}, {31'd0, mon_n < 4});
            check("mon_mem_req", {31'd0, mem_req}, {31'd0, mon_n > 0});
            check("mon_rd_conflict", {31'd0, rd_conflict}, {31'd0, mon_conf});
            if (mon_n > 0) begin
                check("mon_mem_addr", mem_addr, {exp_q[0].waddr, 2'b00});
                check("mon_mem_wdata", mem_wdata, exp_q[0].data);
                check("mon_mem_be", {28'd0, mem_be}, {28'd0, exp_q[0].be});
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit ack);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        mem_ack  = ack;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        mem_ack = 1'b0; rd_addr = 32'hFFFF_FFF0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("reset_rd_conflict", {31'd0, rd_conflict}, 32'd0);

        // Single store, one-cycle latency to the memory port
        cyc(1'b1, 32'h100, 32'hAABBCCDD, 4'b1111, 1'b0);
        check("single_mem_req", {31'd0, mem_req}, 32'd1);
        check("single_mem_addr", mem_addr, 32'h100);
        check("single_mem_be", {28'd0, mem_be}, 32'hF);
        check("single_count", {29'd0, count}, 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("single_ack_empty", {31'd0, empty}, 32'd1);

        // Fill to four with no acks; a fifth store is refused
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h400 + 4*i, 32'h1000 + i, 4'hF, 1'b0);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        cyc(1'b1, 32'h410, 32'hDEAD, 4'hF, 1'b0);
        check("full_refuse_count", {29'd0, count}, 32'd4);
        check("full_head_addr", mem_addr, 32'h400);

        // Ack while full: the concurrent store is still refused
        cyc(1'b1, 32'h414, 32'hBEEF, 4'hF, 1'b1);
        check("full_ack_count", {29'd0, count}, 32'd3);
        check("full_ack_head", mem_addr, 32'h404);
        cyc(1'b1, 32'h418, 32'h2018, 4'hF, 1'b0);
        check("wrap_push_count", {29'd0, count}, 32'd4);
        drain();
        check("drain_empty", {31'd0, empty}, 32'd1);

        // Zero byte-enable store is ignored
        cyc(1'b1, 32'h420, 32'h5555, 4'h0, 1'b0);
        check("be0_ignored", {31'd0, empty}, 32'd1);

        // Same-word store behind a non-head tail entry
        cyc(1'b1, 32'h1F0, 32'h12345678, 4'hF, 1'b0);
        cyc(1'b1, 32'h200, 32'h00000011, 4'b0001, 1'b0);
        cyc(1'b1, 32'h202, 32'h00330000, 4'b0100, 1'b0);
`ifdef WRITE_MERGE_EN
        check("merge_count", {29'd0, count}, 32'd2);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("merge_addr", mem_addr, 32'h200);
        check("merge_be", {28'd0, mem_be}, 32'h5);
        check("merge_data", mem_wdata, 32'h00330011);
`else
        check("nomerge_count", {29'd0, count}, 32'd3);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("nomerge_addr", mem_addr, 32'h200);
        check("nomerge_be", {28'd0, mem_be}, 32'h1);
        check("nomerge_data", mem_wdata, 32'h00000011);
`endif
        drain();

        // Load conflict detection; a store being pushed this cycle does not count
        rd_addr = 32'h300; wr_valid = 1'b1; wr_addr = 32'h300; wr_be = 4'hF; wr_data = 32'h77;
        #1;
        check("conflict_inflight", {31'd0, rd_conflict}, 32'd0);
        cyc(1'b1, 32'h300, 32'h77, 4'hF, 1'b0);
        rd_addr = 32'h303; #1;
        check("conflict_hit", {31'd0, rd_conflict}, 32'd1);
        rd_addr = 32'h304; #1;
        check("conflict_next_word", {31'd0, rd_conflict}, 32'd0);
        rd_addr = 32'h303;
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check("conflict_after_ack", {31'd0, rd_conflict}, 32'd0);

        // Reset beats a simultaneous ack and push
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 4*i, 32'h3000 + i, 4'hF, 1'b0);
        check("pre_rst_count", {29'd0, count}, 32'd3);
        rst = 1'b1;
        cyc(1'b1, 32'h50C, 32'h300C, 4'hF, 1'b1);
        rst = 1'b0;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        rd_addr = 32'h504;
        repeat (2) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("rst_no_stale", {31'd0, mem_req}, 32'd0);
        check("rst_no_conflict", {31'd0, rd_conflict}, 32'd0);
        cyc(1'b1, 32'h600, 32'h6666, 4'hF, 1'b0);
        check("post_rst_head", mem_addr, 32'h600);
        check("post_rst_count", {29'd0, count}, 32'd1);
        drain();

        // Random traffic on a few words so merges, conflicts and stalls all occur
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            rd_addr  = 32'h700 + $urandom_range(0, 15);
            cyc($urandom_range(0, 1) == 1,
                32'h700 + ($urandom_range(0, 2) << 2) + $urandom_range(0, 3),
                $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0);
        end
        rst = 1'b0;
        drain();
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: wr_valid  input  1  store request from memory stage.
REQ-005 SHALL have port: wr_addr  input  32  store byte address; bits [31:2] form the word address.
REQ-006 SHALL have port: wr_data  input  32  store data, already byte-lane positioned.
REQ-007 SHALL have port: wr_be  input  4  byte enables from the byte-enable unit; bit n enables byte lane n.
REQ-008 SHALL have port: wr_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port: mem_req  output  1  head entry presented to data memory.
REQ-010 SHALL have port: mem_addr  output  32  head word address, with bits [1:0] = 0.
REQ-011 SHALL have port: mem_wdata  output  32  head data.
REQ-012 SHALL have port: mem_be  output  4  head byte enables.
REQ-013 SHALL have port: mem_ack  input  1  memory accepted the head this cycle.
REQ-014 SHALL have port: rd_addr  input  32  load address checked against buffered stores.
REQ-015 SHALL have port: rd_conflict  output  1  some valid entry matches rd_addr[31:2]; the CPU stalls the load.
REQ-016 SHALL have port: count  output  3  occupancy, 0..4.
REQ-017 SHALL have port: empty  output  1  count == 0.

Function
REQ-018 SHALL hold 4 entries (word address, data, be) in a circular FIFO with 2-bit head/tail pointers wrapping 3->0.
REQ-019 SHALL drive wr_ready = (count < 4), independent of mem_ack in the same cycle.
REQ-020 SHALL accept (push) when wr_valid && wr_ready && wr_be != 4'b0000; wr_be == 0 is ignored without changing state.
REQ-021 SHALL drive mem_req = !empty; mem_addr, mem_wdata and mem_be are driven combinationally from the head entry.
REQ-022 SHALL keep the head entry unchanged from the first mem_req cycle until the cycle mem_req && mem_ack is seen.
REQ-023 SHALL retire (pop) the head on the clk edge where mem_req && mem_ack; mem_ack while empty is ignored.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop, and SHALL increment or decrement it by 1 on a push or pop alone.
REQ-025 SHALL make an entry pushed at edge N visible on mem_* in cycle N+1 when the buffer was empty before the push (1-cycle latency).
REQ-026 SHALL compute rd_conflict combinationally over valid entries only, excluding the entry being pushed in the same cycle.
REQ-027 SHALL store mem_addr as {wr_addr[31:2], 2'b00}.

Reset
REQ-028 SHALL, on rst at a clk edge, set head = tail = count = 0, clear all entry be fields, and so drive mem_req = 0, empty = 1, count = 0, wr_ready = 1, rd_conflict = 0 from the next cycle.
REQ-029 SHALL discard all buffered entries on a reset mid-transaction, even if mem_ack is high in the same cycle, and SHALL give rst priority over push, pop and merge.

Configuration
REQ-030 SHALL, with WRITE_MERGE_EN defined, merge an accepted store into the tail entry instead of pushing when count >= 2 and tail word address == wr_addr[31:2].
REQ-031 SHALL, on a merge, overwrite byte lane n of the tail data where wr_be[n] = 1, OR wr_be into the tail be, and leave count unchanged.
REQ-032 SHALL never merge into the head entry (count == 1), so the head stays stable under REQ-022.
REQ-033 SHALL, with WRITE_MERGE_EN undefined, treat every accepted store as a push, with no merge logic present.

Verification
REQ-034 SHALL test: reset, then one store addr 0x100, data 0xAABBCCDD, be 4'b1111 -> next cycle mem_req=1, mem_addr=0x100, mem_be=4'b1111, count=1; ack -> empty=1.
REQ-035 SHALL test: 4 stores with mem_ack held 0 -> count=4, wr_ready=0; a 5th wr_valid is not accepted; mem_addr still shows the 1st store.
REQ-036 SHALL test: full buffer, mem_ack=1 and wr_valid=1 in the same cycle -> the store is not accepted and count=3 next cycle; the next push succeeds and pointers wrap to 0.
REQ-037 SHALL test: with WRITE_MERGE_EN and count=2, tail at 0x200 be 4'b0001 data 0x00000011, then store 0x202 be 4'b0100 data 0x00330000 -> count stays 2, and the tail drains as be 4'b0101, data 0x00330011.
REQ-038 SHALL test: entry at 0x300 pending, rd_addr=0x303 -> rd_conflict=1; rd_addr=0x304 -> rd_conflict=0; after ack -> rd_conflict=0.
REQ-039 SHALL test: rst asserted with count=3 and mem_ack=1 -> count=0, mem_req=0 next cycle, and no stale entry reappears afterwards.
